// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive half of the UART. Deserialises start / 8 data (LSB first) /
//   parity / stop frames from the asynchronous rx pin, drops frames with a
//   bad stop bit or bad parity, and queues good bytes in a synchronous FIFO
//   that the host drains with rd_en.
//
// Parameters
//   FIFO_WIDTH   : FIFO data width; a frame always carries 8 data bits
//   FIFO_DEPTH   : FIFO entries, power of two, >= 2
//   ODD_PARITY   : 1 = odd parity, 0 = even parity
//   CLKS_PER_BIT : UART_clk cycles per serial bit, even, >= 4
//
// Ports
//   UART_clk   in  : single clock, rising edge
//   rst        in  : synchronous active-high reset
//   rx         in  : asynchronous serial line, idle high
//   rx_enable  in  : 1 = a new frame may start (does not abort a frame)
//   rd_en      in  : pop one FIFO entry, ignored when empty
//   data_out   out : registered read data, valid the cycle after rd_en
//   empty      out : FIFO holds no entries
//   full       out : FIFO holds FIFO_DEPTH entries
//   parity_err out : one-cycle pulse, frame dropped on parity mismatch
//   frame_err  out : one-cycle pulse, frame dropped on stop bit == 0
//   overflow   out : one-cycle pulse, good frame dropped because FIFO full
module uart_rx_fifo #(
  parameter int FIFO_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int ODD_PARITY   = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  UART_clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rx_enable,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             PAR_ODD  = (ODD_PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // rx synchroniser; both flops reset to the idle level so a reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge UART_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             stop_strobe;

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    stop_strobe = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_enable && !rx_s) state_d = S_START;
      end
      S_START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Return to IDLE on the stop sample itself so a start bit that
        // immediately follows this stop bit is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          stop_strobe = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame evaluation on the stop-sample edge; exactly one outcome fires.
  logic parity_ok;
  logic frame_bad;
  logic parity_bad;
  logic frame_good;
  logic wr_en;
  logic rd_do;

  assign parity_ok  = ((^shift_q) ^ par_q) == PAR_ODD;
  assign frame_bad  = stop_strobe && !rx_s;
  assign parity_bad = stop_strobe && rx_s && !parity_ok;
  assign frame_good = stop_strobe && rx_s && parity_ok;

  // A full FIFO still accepts a write when the same edge pops an entry.
  assign wr_en = frame_good && (!full || rd_en);
  assign rd_do = rd_en && !empty;

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= parity_bad;
      frame_err  <= frame_bad;
      overflow   <= frame_good && !wr_en;
    end
  end

  // ---------------------------------------------------------------------
  // Synchronous FIFO
  // ---------------------------------------------------------------------
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      count_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == OCC_W'(FIFO_DEPTH));

  // NOTE: the storage array has no reset; flushing is done by clearing the
  // pointers and occupancy, and stale contents are never readable.
  always_ff @(posedge UART_clk) begin
    if (wr_en) mem[wr_ptr_q] <= FIFO_WIDTH'(shift_q);
  end

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_do) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_out <= mem[rd_ptr_q];
      end
      unique case ({wr_en, rd_do})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side counterpart of the UART transmit path: deserialises start/8-data/parity/stop frames from the serial `rx` line, checks parity and stop bit, and buffers good bytes in an internal synchronous FIFO for the host to read. Sits between the pad-side serial input and the host/register interface, in the same `UART_clk` domain as the transmit wrapper. Frame format and parity polarity match the transmitter exactly.

## Interface
- `FIFO_WIDTH`, 8, data width; frame always carries 8 data bits.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥2.
- `ODD_PARITY`, 1, 1 = odd parity, 0 = even parity.
- `CLKS_PER_BIT`, 16, `UART_clk` cycles per serial bit; even, ≥4.
- `UART_clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_enable`  in  1  1 = new frames may start; 0 = start bits ignored.
- `rd_en`  in  1  pop one FIFO entry; ignored when `empty`.
- `data_out`  out  FIFO_WIDTH  registered read data.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `parity_err`  out  1  one-cycle pulse: frame dropped, parity mismatch.
- `frame_err`  out  1  one-cycle pulse: frame dropped, stop bit sampled 0.
- `overflow`  out  1  one-cycle pulse: good frame dropped, FIFO full.

## Operation
- `rx` passes a 2-flop synchroniser (both flops reset to 1); FSM sees only `rx_s`.
- Bit counter `cnt` (0..CLKS_PER_BIT-1) and bit index `idx` (0..7).
- IDLE: if `rx_enable` and `rx_s`==0 → START, cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 sample `rx_s`; 1 → IDLE (glitch, no flags); 0 → DATA, cnt=0, idx=0.
- DATA: at cnt==CLKS_PER_BIT-1 shift `rx_s` into bit idx (LSB first); after idx 7 → PARITY.
- PARITY: at cnt==CLKS_PER_BIT-1 capture parity bit → STOP.
- STOP: at cnt==CLKS_PER_BIT-1 sample stop bit, evaluate, → IDLE same edge.
- Parity good when XOR(data, parity bit) == ODD_PARITY.
- Evaluation priority: stop==0 → `frame_err`; else parity bad → `parity_err`; else push if accepted, otherwise `overflow`. Exactly one outcome per frame.
- `rx_enable` only gates IDLE→START; deassertion mid-frame lets the frame complete.
- FIFO: write accepted when `!full` or `rd_en` same cycle; read when `rd_en && !empty`, `data_out` updated on that edge, else held. Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH, `full`/`empty` derived from it.
- Simultaneous read+write: occupancy unchanged; at empty with write, no read occurs (rd_en ignored).

## Timing
- Reset values: `data_out`=0, `empty`=1, `full`=0, all pulses 0, FSM IDLE, pointers/count 0, sync flops 1.
- Reset mid-frame: frame abandoned, FIFO flushed, no flags.
- t0 = cycle FSM sees `rx_s`==0 in IDLE (2 cycles after `rx` falls). Start check at t0+C/2; data bit i sampled at t0+C/2+(i+1)·C; parity at t0+C/2+9·C; stop/push/flag at t0+C/2+10·C (C=CLKS_PER_BIT).
- Push edge: `empty` falls and `full` updates the following cycle; flags high for that one cycle.
- FSM in IDLE immediately after stop sample; back-to-back frames with no idle gap received.
- Read latency: `data_out` valid the cycle after `rd_en` is sampled.

## Test plan
- Odd parity, C=16: send 0xA5 parity 1 stop 1 → `empty` falls at t0+168+1; `rd_en` pulse → `data_out`=0xA5 next cycle, `empty`=1, no flags.
- Send 0x01 with parity bit 1 (odd mode) → `parity_err` pulse at stop sample, FIFO stays empty; repeat with stop bit 0 → `frame_err` only.
- 2-cycle-per-… glitch: `rx` low for 4 cycles then high → FSM returns IDLE at start check, no push, no flags.
- Send 17 back-to-back good frames 0x00..0x10, no reads → `full`=1 after 16th, `overflow` pulse on 17th; read all → 0x00..0x0F in order, `empty`=1.
- With FIFO full, assert `rd_en` on the 17th frame's stop-sample cycle → no `overflow`, `full` stays 1, last entry = 0x10.
- Assert `rst` at mid DATA of a frame, FIFO holding 3 entries → next cycle `empty`=1, `data_out`=0; line idle then fresh 0x5A received correctly; `rx_enable`=0 during a start → nothing received.
